// File: rtl/i2s_pkg.sv
// Shared types and width helpers for the I2S/TDM transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } eng_state_e;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Index width for a storage of 'depth' entries (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold the values 0..depth inclusive, for a power-of-2 depth.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_tx_multi_fifo.sv
// frame_fifo: synchronous FIFO holding whole frames, with occupancy count.
module frame_fifo import i2s_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [WIDTH-1:0]          wdata_i,
  output logic [WIDTH-1:0]          rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [lvl_w(DEPTH)-1:0]   level_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset; entries are only read while counted by level_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: frame FIFO plus serializer producing bck/lrck/sdata.
// Define I2S_TDM_EN for TDM mode (CHANNELS 2..8, one-BCK frame-sync pulse);
// without it only two-channel I2S is built.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | outputs held low, waiting for enable
// LOAD   | one clk: pop a frame (or zeros on underrun) into the shifter
// SHIFT  | clock out CHANNELS*SLOT_W bit periods
module i2s_tx_multi import i2s_pkg::*; #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int BCK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0]   sample_data,
  output logic                           bck,
  output logic                           lrck,
  output logic                           sdata,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   fifo_level,
  output logic [15:0]                    underrun_cnt
);

  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam int NBITS   = CHANNELS * SLOT_W;
  localparam int BW      = cnt_w(NBITS);
  localparam int DW      = cnt_w(BCK_DIV);
  localparam int LW      = lvl_w(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(BCK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);

`ifdef I2S_TDM_EN
  if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
    $error("i2s_tx_multi: CHANNELS must be 2..8 in TDM mode");
  end
`else
  if (CHANNELS != 2) begin : g_bad_channels
    $error("i2s_tx_multi: CHANNELS must be 2 without I2S_TDM_EN");
  end
`endif
  if (SLOT_W < SAMPLE_W || BCK_DIV < 1) begin : g_bad_timing
    $error("i2s_tx_multi: need SLOT_W >= SAMPLE_W and BCK_DIV >= 1");
  end

  eng_state_e       state_q;
  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic [NBITS-1:0] sr_q;
  logic [NBITS-1:0] frame_bits;
  logic             bck_q, lrck_q, sdata_q, ready_q;
  logic [15:0]      under_q;
  logic [FRAME_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, push, pop;
  logic [LW-1:0]    lvl_nxt;

  // lrck level for a given bit period; data is always one period late.
  function automatic logic ws_of(input logic [BW-1:0] b);
`ifdef I2S_TDM_EN
    return (b == '0);
`else
    return (b >= BW'(SLOT_W));
`endif
  endfunction

  // ready_q is a registered copy of !full; full gate is a redundant safety.
  assign push = sample_valid && ready_q && !fifo_full;
  assign pop  = (state_q == ST_LOAD) && !fifo_empty;

  frame_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (sample_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign lvl_nxt = fifo_level + LW'(push) - LW'(pop);

  // Registered ready, low while the FIFO will hold FIFO_DEPTH frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= (lvl_nxt != LW'(FIFO_DEPTH));
  end

  // Slot layout: channel 0 first, each sample MSB first then zero padding.
  always_comb begin
    frame_bits = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      frame_bits[NBITS-1-ch*SLOT_W -: SAMPLE_W] = fifo_rdata[ch*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Frame engine: divider, bit counter and shifter with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      under_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bck_q   <= 1'b0;
          sdata_q <= 1'b0;
          div_q   <= DIV_RELOAD;
          bit_q   <= '0;
          lrck_q  <= 1'b0;
          if (enable) begin
            state_q <= ST_LOAD;
            lrck_q  <= ws_of(BW'(0));
          end
        end
        ST_LOAD: begin
          sr_q <= fifo_empty ? '0 : frame_bits;
          if (fifo_empty && under_q != UNDERRUN_MAX) under_q <= under_q + 1'b1;
          // The LOAD cycle is the first clk of bit 0's low phase.
          if (div_q == '0) begin
            div_q <= DIV_RELOAD;
            bck_q <= 1'b1;
          end else begin
            div_q <= div_q - 1'b1;
          end
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - 1'b1;
          end else begin
            div_q <= DIV_RELOAD;
            if (!bck_q) begin
              bck_q <= 1'b1;
            end else begin
              bck_q   <= 1'b0;
              sdata_q <= sr_q[NBITS-1];
              if (bit_q == LAST_BIT) begin
                // The frame's last bit goes out in bit 0 of the next frame.
                bit_q <= '0;
                if (enable) begin
                  state_q <= ST_LOAD;
                  lrck_q  <= ws_of(BW'(0));
                end else begin
                  state_q <= ST_IDLE;
                  lrck_q  <= 1'b0;
                  sdata_q <= 1'b0;
                end
              end else begin
                bit_q  <= bit_q + 1'b1;
                lrck_q <= ws_of(bit_q + 1'b1);
                sr_q   <= sr_q << 1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign sdata        = sdata_q;
  assign underrun_cnt = under_q;

endmodule

// File: doc/i2s_tx_multi.md
I2S_TX_MULTI -- requirements
Module: i2s_tx_multi

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning bits per channel sample (8..32).
REQ-002 SHALL have parameter SLOT_W, default 32, meaning BCK periods per channel slot (at least SAMPLE_W).
REQ-003 SHALL have parameter CHANNELS, default 2, meaning channels per frame (2 in I2S mode; 2..8 in TDM mode).
REQ-004 SHALL have parameter BCK_DIV, default 4, meaning clk cycles per BCK half-period (at least 1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning frame FIFO entries (a power of 2, at least 2).
REQ-006 SHALL have port clk, input, width 1: the single clock.
REQ-007 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, width 1: serializer run request.
REQ-009 SHALL have port sample_valid, input, width 1: a frame is offered.
REQ-010 SHALL have port sample_ready, output, width 1: the FIFO is not full.
REQ-011 SHALL have port sample_data, input, width CHANNELS*SAMPLE_W: channel n occupies bits [n*SAMPLE_W +: SAMPLE_W], two's complement.
REQ-012 SHALL have port bck, output, width 1: the bit clock.
REQ-013 SHALL have port lrck, output, width 1: word select (I2S mode) or frame sync (TDM mode).
REQ-014 SHALL have port sdata, output, width 1: serial data.
REQ-015 SHALL have port fifo_level, output, width clog2(FIFO_DEPTH)+1: frames held in the FIFO.
REQ-016 SHALL have port underrun_cnt, output, width 16: saturating count of frames sent with no data.

Function
REQ-017 A frame SHALL be pushed on a clk edge where sample_valid and sample_ready are both high; sample_ready SHALL be registered and SHALL be low when fifo_level equals FIFO_DEPTH.
REQ-018 A push and a pop in the same cycle SHALL leave fifo_level unchanged; a push while full SHALL not occur because sample_ready is low.
REQ-019 The BCK divider SHALL toggle bck every BCK_DIV clk cycles while running; sdata and lrck SHALL change only on bck falling edges.
REQ-020 The frame engine SHALL have states IDLE, LOAD and SHIFT.
- IDLE to LOAD: enable is high.
- LOAD: lasts one clk cycle; pops one frame into the shift register, or loads all zeros and increments underrun_cnt (saturating at 16'hFFFF) if the FIFO is empty; then goes to SHIFT.
- SHIFT: sends CHANNELS*SLOT_W bits.
- At the end of the last bit: go to LOAD if enable is high, otherwise to IDLE.
REQ-021 Each slot SHALL send its sample MSB first and then SLOT_W-SAMPLE_W zero bits.
REQ-022 In I2S mode, lrck SHALL be low for channel 0 and high for channel 1, and the MSB SHALL be sent one BCK period after each lrck transition (the standard I2S one-bit delay).
REQ-023 Latency: a frame pushed into an empty FIFO while the engine is in SHIFT SHALL be sent in the next frame; the bits of the current frame SHALL not change.
REQ-024 A deassertion of enable SHALL take effect only at a frame boundary; partial frames SHALL never be sent.
REQ-025 In IDLE, bck, lrck and sdata SHALL be held low, and the FIFO SHALL still accept pushes.

Reset
REQ-026 While reset_n is low, all of the following SHALL hold asynchronously, including in the middle of a frame:
- FIFO empty, fifo_level=0
- sample_ready=0, becoming 1 on the first clk edge after release
- bck=0, lrck=0, sdata=0
- underrun_cnt=0
- state IDLE, divider and bit counters 0
REQ-027 A frame interrupted by reset SHALL be lost and SHALL not be resumed.

Configuration
REQ-028 With macro I2S_TDM_EN defined:
- CHANNELS 2..8 SHALL be legal.
- lrck SHALL be a one-BCK-wide high pulse during the final bit of the previous frame.
- The channel 0 MSB SHALL follow the pulse on the next BCK period.
REQ-029 Without I2S_TDM_EN:
- Only I2S mode SHALL exist.
- CHANNELS other than 2 SHALL cause an elaboration error.

Structure
REQ-030 Package i2s_pkg SHALL hold the frame-engine state enum, the clog2-based width helper functions and the UNDERRUN_MAX constant.
REQ-031 The FIFO SHALL be a sub-module named frame_fifo, parametrised by width and depth, that provides full, empty and level outputs.

Verification
REQ-032 Defaults, enable=1, one frame L=16'hA5A5, R=16'h5A5A pushed -> after the one-bit delay sdata shows 1010010110100101 followed by 16 zeros with lrck=0, then the R pattern with lrck=1; underrun_cnt=0 for that frame.
REQ-033 Push 5 frames back-to-back with enable=0 and FIFO_DEPTH=4 -> sample_ready=0 after the 4th push; fifo_level=4; the 5th frame is not accepted.
REQ-034 enable=1 with the FIFO empty for 3 frames -> all-zero sdata; underrun_cnt=3.
REQ-035 Drop enable at the midpoint of a frame -> the frame completes all 64 bits; then bck, lrck and sdata are held 0.
REQ-036 Assert reset_n=0 at bit 20 of slot 1 -> all outputs are immediately 0 and fifo_level=0; after release, sample_ready=1 on the first clk edge.
REQ-037 With I2S_TDM_EN, CHANNELS=4, SLOT_W=16, channel n = 16'h1111*(n+1) -> a one-BCK lrck pulse, then 64 bits in the order 1111, 2222, 3333, 4444.
